// File: rtl/altsqrt_pipe_avmm_bridge_if.sv
// Avalon-MM slave bus bundle for the ALTSQRT CSR bridge.
// Host side drives the master modport; the bridge takes the slave modport.
interface altsqrt_pipe_avmm_bridge_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/altsqrt_pipe_avmm_bridge.sv
// CSR bridge that launches one ALTSQRT pipeline operation per START and captures
// root/remainder PIPE_LATENCY+1 clocks later, with status, counter and interrupt.
module altsqrt_pipe_avmm_bridge #(
    parameter int RADICAL_W    = 8,
    parameter int PIPE_LATENCY = 2,
    localparam int Q_W         = RADICAL_W / 2,
    localparam int REM_W       = RADICAL_W / 2 + 1
) (
    input  logic                         clk,
    input  logic                         areset,
    altsqrt_pipe_avmm_bridge_if.slave    avs,
    output logic                         irq,
    output logic [RADICAL_W-1:0]         altsqrt_radical,
    input  logic [Q_W-1:0]               altsqrt_q,
    input  logic [REM_W-1:0]             altsqrt_remainder
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cntNext;
    logic [RADICAL_W-1:0] r_radical;
    logic [Q_W-1:0]       r_q;
    logic [REM_W-1:0]     r_rem;
    logic [31:0]          r_count;
    logic                 r_done;
    logic                 r_overrun;
    logic                 r_irqEn;
    logic                 r_irq;
    logic [31:0]          r_readdata;
    logic                 r_readdatavalid;

    logic                 w_busy;
    logic                 w_radWr;
    logic                 w_ctrlWr;
    logic                 w_statusWr;
    logic                 w_startReq;
    logic                 w_start;
    logic                 w_capture;
    logic                 w_overrunEvt;
    logic [31:0]          w_rdMux;
    logic                 w_unused;

    assign w_busy       = (r_state == S_WAIT);
    assign w_radWr      = avs.avs_write && (avs.avs_address == 3'd0);
    assign w_ctrlWr     = avs.avs_write && (avs.avs_address == 3'd1);
    assign w_statusWr   = avs.avs_write && (avs.avs_address == 3'd2);
    assign w_startReq   = w_ctrlWr && avs.avs_writedata[0];
    assign w_start      = !w_busy && w_startReq;
    assign w_capture    = w_busy && (r_cnt == 4'd0);
    assign w_overrunEvt = w_busy && (w_startReq || w_radWr);
    assign w_unused     = ^avs.avs_writedata;

    assign altsqrt_radical       = r_radical;
    assign irq                   = r_irq;
    assign avs.avs_readdata      = r_readdata;
    assign avs.avs_readdatavalid = r_readdatavalid;

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_startReq) begin
                    w_stateNext = S_WAIT;
                    w_cntNext   = 4'(PIPE_LATENCY);
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_stateNext = S_IDLE;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_cntNext   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Sticky status bits: a set event in the same cycle as a W1C wins.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_radical <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_count   <= 32'd0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_irqEn   <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_radWr && !w_busy) begin
                r_radical <= avs.avs_writedata[RADICAL_W-1:0];
            end
            if (w_ctrlWr) begin
                r_irqEn <= avs.avs_writedata[1];
            end
            if (w_capture) begin
                r_q     <= altsqrt_q;
                r_rem   <= altsqrt_remainder;
                r_count <= r_count + 32'd1;
            end
            if (w_capture) begin
                r_done <= 1'b1;
            end else if (w_start) begin
                r_done <= 1'b0;
            end else if (w_statusWr && avs.avs_writedata[1]) begin
                r_done <= 1'b0;
            end
            if (w_overrunEvt) begin
                r_overrun <= 1'b1;
            end else if (w_statusWr && avs.avs_writedata[2]) begin
                r_overrun <= 1'b0;
            end
            r_irq <= r_done && r_irqEn;
        end
    end

    always_comb begin
        w_rdMux = 32'd0;
        case (avs.avs_address)
            3'd0:    w_rdMux = 32'(r_radical);
            3'd1:    w_rdMux = {30'd0, r_irqEn, 1'b0};
            3'd2:    w_rdMux = {29'd0, r_overrun, r_done, w_busy};
            3'd3:    w_rdMux = 32'(r_q);
            3'd4:    w_rdMux = 32'(r_rem);
            3'd5:    w_rdMux = r_count;
            3'd6:    w_rdMux = {16'd0, 8'(PIPE_LATENCY), 8'(RADICAL_W)};
            default: w_rdMux = 32'd0;
        endcase
    end

    // Read data reflects register state before any write taking effect this edge.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_readdata      <= 32'd0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= avs.avs_read;
            r_readdata      <= avs.avs_read ? w_rdMux : 32'd0;
        end
    end

endmodule

// File: tb/tb_altsqrt_pipe_avmm_bridge.sv
// Directed self-checking bench: default bridge with a 2-stage sqrt pipeline model,
// plus a 16-bit zero-latency instance.
module tb_altsqrt_pipe_avmm_bridge;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        sel = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        rvalid;

    int passCount = 0;
    int checkCount = 0;

    logic       irqA, irqB;
    logic [7:0] radA;
    logic [3:0] qA, pq1, pq2;
    logic [4:0] remA, pr1, pr2;
    logic [15:0] radB;
    logic [7:0]  qB;
    logic [8:0]  remB;

    altsqrt_pipe_avmm_bridge_if ifA ();
    altsqrt_pipe_avmm_bridge_if ifB ();

    always #5 clk = ~clk;

    assign ifA.avs_address   = addr;
    assign ifA.avs_writedata = wdata;
    assign ifA.avs_read      = rd & ~sel;
    assign ifA.avs_write     = wr & ~sel;
    assign ifB.avs_address   = addr;
    assign ifB.avs_writedata = wdata;
    assign ifB.avs_read      = rd & sel;
    assign ifB.avs_write     = wr & sel;
    assign rdata  = sel ? ifB.avs_readdata : ifA.avs_readdata;
    assign rvalid = sel ? ifB.avs_readdatavalid : ifA.avs_readdatavalid;

    altsqrt_pipe_avmm_bridge dutA (
        .clk               (clk),
        .areset            (areset),
        .avs               (ifA.slave),
        .irq               (irqA),
        .altsqrt_radical   (radA),
        .altsqrt_q         (qA),
        .altsqrt_remainder (remA)
    );

    altsqrt_pipe_avmm_bridge #(.RADICAL_W(16), .PIPE_LATENCY(0)) dutB (
        .clk               (clk),
        .areset            (areset),
        .avs               (ifB.slave),
        .irq               (irqB),
        .altsqrt_radical   (radB),
        .altsqrt_q         (qB),
        .altsqrt_remainder (remB)
    );

    function automatic int isqrt(input int x);
        int q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
        return q;
    endfunction

    // Two-stage model of the attached sqrt core for the default instance.
    always @(posedge clk) begin
        pq1 <= 4'(isqrt(int'(radA)));
        pr1 <= 5'(int'(radA) - isqrt(int'(radA)) * isqrt(int'(radA)));
        pq2 <= pq1;
        pr2 <= pr1;
    end
    assign qA   = pq2;
    assign remA = pr2;
    assign qB   = 8'(isqrt(int'(radB)));
    assign remB = 9'(int'(radB) - isqrt(int'(radB)) * isqrt(int'(radB)));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk);
        #1 wr = 1'b0;
    endtask

    task automatic checkRead(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        checkOutput({tag, "_valid"}, {31'd0, rvalid}, 32'd1);
        checkOutput(tag, rdata, exp);
    endtask

    task automatic doReset();
        @(negedge clk);
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        checkOutput("rst_irq", {31'd0, irqA}, 32'd0);
        checkOutput("rst_radical_port", {24'd0, radA}, 32'd0);
        checkOutput("rst_rdvalid", {31'd0, rvalid}, 32'd0);
        checkRead("params_default", 3'd6, 32'h0000_0208);
        checkRead("rst_status", 3'd2, 32'd0);
        checkRead("rst_count", 3'd5, 32'd0);
        @(posedge clk); #1;
        checkOutput("idle_rdvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("idle_rdata", rdata, 32'd0);

        // Basic operation, radical 200, latency 2
        applyStimulus(3'd0, 32'd200);
        applyStimulus(3'd1, 32'd1);
        checkOutput("radical_port", {24'd0, radA}, 32'd200);
        checkRead("busy_t1", 3'd2, 32'd1);
        checkRead("busy_t2", 3'd2, 32'd1);
        checkRead("busy_t3", 3'd2, 32'd1);
        checkRead("done_t4", 3'd2, 32'd2);
        checkRead("q_200", 3'd3, 32'd14);
        checkRead("rem_200", 3'd4, 32'd4);
        checkRead("count_1", 3'd5, 32'd1);
        checkRead("radical_rb", 3'd0, 32'd200);

        // Interrupt rise after capture and fall after W1C
        applyStimulus(3'd2, 32'd2);
        applyStimulus(3'd1, 32'd3);
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("irq_before_cap", {31'd0, irqA}, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("irq_after_cap", {31'd0, irqA}, 32'd1);
        checkRead("ctrl_rb", 3'd1, 32'd2);
        applyStimulus(3'd2, 32'd2);
        @(posedge clk); #1;
        checkOutput("irq_after_clr", {31'd0, irqA}, 32'd0);
        checkRead("count_2", 3'd5, 32'd2);

        // Overrun: START, START, RADICAL write on consecutive edges
        doReset();
        checkRead("rst2_q", 3'd3, 32'd0);
        applyStimulus(3'd0, 32'd200);
        applyStimulus(3'd1, 32'd1);
        applyStimulus(3'd1, 32'd1);
        applyStimulus(3'd0, 32'd99);
        repeat (3) @(posedge clk);
        checkRead("ovr_status", 3'd2, 32'd6);
        checkRead("ovr_q", 3'd3, 32'd14);
        checkRead("ovr_radical", 3'd0, 32'd200);
        checkRead("ovr_count", 3'd5, 32'd1);
        applyStimulus(3'd2, 32'd6);
        checkRead("status_clr", 3'd2, 32'd0);

        // W1C DONE coinciding with the capture edge
        applyStimulus(3'd1, 32'd1);
        repeat (2) @(posedge clk);
        applyStimulus(3'd2, 32'd2);
        checkRead("done_set_wins", 3'd2, 32'd2);
        checkRead("count_after_w1c", 3'd5, 32'd2);

        // Simultaneous read and write returns the pre-write value
        @(negedge clk);
        addr = 3'd0; wdata = 32'd50; rd = 1'b1; wr = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0; wr = 1'b0;
        checkOutput("rw_old_value", rdata, 32'd200);
        checkRead("rw_new_value", 3'd0, 32'd50);
        applyStimulus(3'd7, 32'hFFFF_FFFF);
        checkRead("addr7", 3'd7, 32'd0);

        // Reset one edge into an operation aborts it
        applyStimulus(3'd1, 32'd3);
        areset = 1'b1;
        @(posedge clk);
        #1 areset = 1'b0;
        repeat (4) @(posedge clk);
        checkRead("abort_status", 3'd2, 32'd0);
        checkRead("abort_count", 3'd5, 32'd0);
        checkRead("abort_radical", 3'd0, 32'd0);
        checkRead("abort_q", 3'd3, 32'd0);
        checkRead("abort_rem", 3'd4, 32'd0);
        checkRead("abort_ctrl", 3'd1, 32'd0);
        checkOutput("abort_irq", {31'd0, irqA}, 32'd0);

        // 16-bit radical, zero latency instance
        sel = 1'b1;
        checkRead("params_b", 3'd6, 32'h0000_0010);
        applyStimulus(3'd0, 32'd65535);
        applyStimulus(3'd1, 32'd1);
        checkRead("b_busy_t1", 3'd2, 32'd1);
        checkRead("b_q_t2", 3'd3, 32'd255);
        checkRead("b_rem", 3'd4, 32'd510);
        checkRead("b_status", 3'd2, 32'd2);
        checkRead("b_count", 3'd5, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
